// File: rtl/regfile_pkg.sv
// Shared widths and types for the multi-port register file.
// Defaults match the 16-entry, 32-bit ARM register set with r15 mapped to the PC.
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 4;
  localparam int RF_PC_IDX = 2**RF_ADDR_W - 1;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file access bus: write ports A/B, packed read ports, scoreboard set and status.
// Purely combinational wiring; no handshake, the register file never backpressures.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 3
) ();

  logic                     we_a;
  logic [ADDR_W-1:0]        wa_a;
  logic [DATA_W-1:0]        wd_a;
  logic                     we_b;
  logic [ADDR_W-1:0]        wa_b;
  logic [DATA_W-1:0]        wd_b;
  logic [DATA_W-1:0]        pc_in;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     sb_set;
  logic [ADDR_W-1:0]        sb_addr;
  logic [ADDR_W:0]          busy_cnt;
  logic                     sb_err;

  modport master (
    output we_a, wa_a, wd_a, we_b, wa_b, wd_b, pc_in, ra, sb_set, sb_addr,
    input  rd, rd_busy, busy_cnt, sb_err
  );

  modport slave (
    input  we_a, wa_a, wd_a, we_b, wa_b, wd_b, pc_in, ra, sb_set, sb_addr,
    output rd, rd_busy, busy_cnt, sb_err
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard: per-register pending-write bits, registered popcount and one-cycle sb_err pulse.
// All outputs update one edge after the set/clear request; never stalls its inputs.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int NUM_REGS = 2**ADDR_W,
  parameter int PC_IDX   = 2**ADDR_W - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REGS-1:0] clr,
  input  logic                sb_set,
  input  logic [ADDR_W-1:0]   sb_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [ADDR_W:0]     busy_cnt,
  output logic                sb_err
);

  localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W:0]     cnt_nxt;
  logic                set_ok;
  logic                err_nxt;

  always_comb begin
    set_ok   = sb_set && (sb_addr != PC_A);
    // Clear first, then set, so a new producer issued alongside the retiring write keeps the bit.
    busy_nxt = busy & ~clr;
    if (set_ok) begin
      busy_nxt[sb_addr] = 1'b1;
    end
    err_nxt = sb_set && (!set_ok || (busy[sb_addr] && !clr[sb_addr]));
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + (ADDR_W+1)'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      busy_cnt <= '0;
      sb_err   <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
      sb_err   <= err_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: combinational reads (PC_IDX returns pc_in), registered A/B writes, A wins on collision.
// Writes visible the cycle after the edge; REGFILE_BYPASS_EN enables same-cycle forwarding. No backpressure.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W,
  parameter int NUM_RD = 3,
  parameter int PC_IDX = 2**ADDR_W - 1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave bus
);

  localparam int                NUM_REGS = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] PC_A     = ADDR_W'(PC_IDX);

  logic [DATA_W-1:0]        regs [NUM_REGS];
  logic                     eff_a;
  logic                     eff_b;
  logic [NUM_REGS-1:0]      clr;
  logic [NUM_REGS-1:0]      busy;
  logic [NUM_RD*DATA_W-1:0] rd_pk;
  logic [NUM_RD-1:0]        busy_pk;
  logic [ADDR_W-1:0]        ra_i;
  logic [DATA_W-1:0]        rd_v;
  logic                     busy_v;
`ifdef REGFILE_BYPASS_EN
  logic                     hit;
`endif

  assign eff_a = bus.we_a && (bus.wa_a != PC_A);
  assign eff_b = bus.we_b && (bus.wa_b != PC_A) && !(eff_a && (bus.wa_a == bus.wa_b));

  always_comb begin
    clr = '0;
    if (eff_a) begin
      clr[bus.wa_a] = 1'b1;
    end
    if (eff_b) begin
      clr[bus.wa_b] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (eff_b) begin
        regs[bus.wa_b] <= bus.wd_b;
      end
      if (eff_a) begin
        regs[bus.wa_a] <= bus.wd_a;
      end
    end
  end

  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .PC_IDX   (PC_IDX)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .sb_set   (bus.sb_set),
    .sb_addr  (bus.sb_addr),
    .busy     (busy),
    .busy_cnt (bus.busy_cnt),
    .sb_err   (bus.sb_err)
  );

  always_comb begin
    rd_pk   = '0;
    busy_pk = '0;
    ra_i    = '0;
    rd_v    = '0;
    busy_v  = 1'b0;
`ifdef REGFILE_BYPASS_EN
    hit     = 1'b0;
`endif
    for (int i = 0; i < NUM_RD; i++) begin
      ra_i   = bus.ra[i*ADDR_W +: ADDR_W];
      rd_v   = regs[ra_i];
      busy_v = busy[ra_i];
`ifdef REGFILE_BYPASS_EN
      hit = 1'b0;
      if (eff_a && (bus.wa_a == ra_i)) begin
        rd_v = bus.wd_a;
        hit  = 1'b1;
      end else if (bus.we_b && (bus.wa_b != PC_A) && (bus.wa_b == ra_i)) begin
        rd_v = bus.wd_b;
        hit  = 1'b1;
      end
      // A retiring write hides the busy bit unless a new producer claims the same register.
      if (hit && !(bus.sb_set && (bus.sb_addr == ra_i))) begin
        busy_v = 1'b0;
      end
`endif
      if (ra_i == PC_A) begin
        rd_v   = bus.pc_in;
        busy_v = 1'b0;
      end
      rd_pk[i*DATA_W +: DATA_W] = rd_v;
      busy_pk[i]                = busy_v;
    end
  end

  assign bus.rd      = rd_pk;
  assign bus.rd_busy = busy_pk;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an array-based model of the register file rules.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int       NRD = 3;
  localparam rf_addr_t PC  = rf_addr_t'(RF_PC_IDX);

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  rf_data_t m_reg  [16];
  logic     m_busy [16];
  logic     m_err;

  regfile_mp_if #(.DATA_W(RF_DATA_W), .ADDR_W(RF_ADDR_W), .NUM_RD(NRD)) bus ();

  regfile_mp #(
    .DATA_W (RF_DATA_W),
    .ADDR_W (RF_ADDR_W),
    .NUM_RD (NRD),
    .PC_IDX (RF_PC_IDX)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic rf_data_t exp_rd(input rf_addr_t a);
    if (a == PC) return bus.pc_in;
`ifdef REGFILE_BYPASS_EN
    if (bus.we_a && bus.wa_a == a) return bus.wd_a;
    if (bus.we_b && bus.wa_b == a) return bus.wd_b;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input rf_addr_t a);
    if (a == PC) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (((bus.we_a && bus.wa_a == a) || (bus.we_b && bus.wa_b == a)) &&
        !(bus.sb_set && bus.sb_addr == a)) return 1'b0;
`endif
    return m_busy[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  task automatic idle();
    bus.we_a = 1'b0; bus.wa_a = '0; bus.wd_a = '0;
    bus.we_b = 1'b0; bus.wa_b = '0; bus.wd_b = '0;
    bus.sb_set = 1'b0; bus.sb_addr = '0; bus.ra = '0;
  endtask

  task automatic set_ra(input rf_addr_t a0, input rf_addr_t a1, input rf_addr_t a2);
    bus.ra = {a2, a1, a0};
  endtask

  // Apply the rules to the inputs present at the coming edge, then commit after it.
  task automatic step();
    rf_data_t nreg  [16];
    logic     nbusy [16];
    logic     nerr;
    logic     ea, eb;
    rf_addr_t s;
    nreg  = m_reg;
    nbusy = m_busy;
    ea = bus.we_a && bus.wa_a != PC;
    eb = bus.we_b && bus.wa_b != PC && !(ea && bus.wa_a == bus.wa_b);
    if (eb) begin nreg[bus.wa_b] = bus.wd_b; nbusy[bus.wa_b] = 1'b0; end
    if (ea) begin nreg[bus.wa_a] = bus.wd_a; nbusy[bus.wa_a] = 1'b0; end
    s    = bus.sb_addr;
    nerr = 1'b0;
    if (bus.sb_set) begin
      if (s == PC) nerr = 1'b1;
      else begin
        if (m_busy[s] && nbusy[s]) nerr = 1'b1;
        nbusy[s] = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    m_reg  = nreg;
    m_busy = nbusy;
    m_err  = nerr;
  endtask

  task automatic test_reset();
    rf_addr_t a;
    reset = 1'b0;
    idle();
    bus.pc_in = 32'h0000_1000;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.busy_cnt !== 5'd0 || bus.sb_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold busy_cnt=%0d sb_err=%b want 0/0", bus.busy_cnt, bus.sb_err);
    end
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    for (int g = 0; g < 6; g++) begin
      set_ra(rf_addr_t'((g*3) % 16), rf_addr_t'((g*3+1) % 16), rf_addr_t'((g*3+2) % 16));
      #1;
      for (int p = 0; p < NRD; p++) begin
        a = bus.ra[p*4 +: 4];
        checks++;
        if (bus.rd[p*32 +: 32] !== ((a == PC) ? 32'h0000_1000 : 32'h0) || bus.rd_busy[p] !== 1'b0) begin
          failures++;
          $display("FAIL reset_read r%0d rd=%h busy=%b want %h/0", a, bus.rd[p*32 +: 32], bus.rd_busy[p],
                   (a == PC) ? 32'h0000_1000 : 32'h0);
        end
      end
    end
    checks++;
    if (bus.busy_cnt !== 5'd0 || bus.sb_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_status busy_cnt=%0d sb_err=%b want 0/0", bus.busy_cnt, bus.sb_err);
    end
  endtask

  task automatic test_collision();
    idle();
    bus.we_a = 1'b1; bus.wa_a = 4'd3; bus.wd_a = 32'hAAAA_0001;
    bus.we_b = 1'b1; bus.wa_b = 4'd3; bus.wd_b = 32'hBBBB_0002;
    step();
    idle();
    set_ra(4'd3, 4'd3, 4'd3);
    #1;
    for (int p = 0; p < NRD; p++) begin
      checks++;
      if (bus.rd[p*32 +: 32] !== 32'hAAAA_0001) begin
        failures++;
        $display("FAIL collision port%0d rd=%h want aaaa0001", p, bus.rd[p*32 +: 32]);
      end
    end
  endtask

  task automatic test_pc_write();
    rf_addr_t a;
    idle();
    bus.we_b = 1'b1; bus.wa_b = 4'd15; bus.wd_b = 32'hDEAD_BEEF;
    step();
    idle();
    bus.pc_in = 32'h0000_2000;
    for (int i = 0; i < 16; i++) begin
      a = rf_addr_t'(i);
      set_ra(a, a, a);
      #1;
      checks++;
      if (bus.rd[31:0] !== exp_rd(a)) begin
        failures++;
        $display("FAIL pc_write r%0d rd=%h want %h", a, bus.rd[31:0], exp_rd(a));
      end
    end
    checks++;
    if (bus.rd[31:0] !== 32'h0000_2000 || bus.busy_cnt !== 5'd0) begin
      failures++;
      $display("FAIL pc_read rd=%h busy_cnt=%0d want 00002000/0", bus.rd[31:0], bus.busy_cnt);
    end
  endtask

  task automatic test_scoreboard();
    idle();
    bus.sb_set = 1'b1; bus.sb_addr = 4'd5;
    step();
    idle();
    set_ra(4'd5, 4'd0, 4'd15);
    #1;
    checks++;
    if (bus.busy_cnt !== 5'd1 || bus.rd_busy !== 3'b001) begin
      failures++;
      $display("FAIL sb_set busy_cnt=%0d rd_busy=%b want 1/001", bus.busy_cnt, bus.rd_busy);
    end
    bus.we_a = 1'b1; bus.wa_a = 4'd5; bus.wd_a = 32'h5555_5555;
    bus.sb_set = 1'b1; bus.sb_addr = 4'd5;
    step();
    idle();
    set_ra(4'd5, 4'd0, 4'd15);
    #1;
    checks++;
    if (bus.busy_cnt !== 5'd1 || bus.rd_busy[0] !== 1'b1 || bus.sb_err !== 1'b0) begin
      failures++;
      $display("FAIL sb_set_and_clear busy_cnt=%0d busy=%b err=%b want 1/1/0", bus.busy_cnt, bus.rd_busy[0], bus.sb_err);
    end
    bus.we_a = 1'b1; bus.wa_a = 4'd5; bus.wd_a = 32'h6666_6666;
    step();
    idle();
    set_ra(4'd5, 4'd0, 4'd15);
    #1;
    checks++;
    if (bus.busy_cnt !== 5'd0 || bus.rd_busy[0] !== 1'b0 || bus.rd[31:0] !== 32'h6666_6666) begin
      failures++;
      $display("FAIL sb_clear busy_cnt=%0d busy=%b rd=%h want 0/0/66666666", bus.busy_cnt, bus.rd_busy[0], bus.rd[31:0]);
    end
  endtask

  task automatic test_illegal_set();
    logic [4:0] exp_cnt [5];
    logic       exp_err [5];
    exp_cnt = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
    exp_err = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      idle();
      if (k < 2) begin bus.sb_set = 1'b1; bus.sb_addr = 4'd7; end
      if (k == 3) begin bus.sb_set = 1'b1; bus.sb_addr = 4'd15; end
      step();
      checks++;
      if (bus.sb_err !== exp_err[k] || bus.busy_cnt !== exp_cnt[k] || bus.sb_err !== m_err) begin
        failures++;
        $display("FAIL illegal_set step%0d sb_err=%b busy_cnt=%0d want %b/%0d", k, bus.sb_err, bus.busy_cnt,
                 exp_err[k], exp_cnt[k]);
      end
    end
    idle();
    bus.we_b = 1'b1; bus.wa_b = 4'd7; bus.wd_b = 32'h7777_0007;
    step();
    checks++;
    if (bus.busy_cnt !== 5'd0) begin
      failures++;
      $display("FAIL illegal_clear busy_cnt=%0d want 0", bus.busy_cnt);
    end
  endtask

  task automatic test_bypass();
    rf_data_t want;
    idle();
    bus.we_a = 1'b1; bus.wa_a = 4'd2; bus.wd_a = 32'h0000_0055;
    step();
    idle();
    bus.we_a = 1'b1; bus.wa_a = 4'd2; bus.wd_a = 32'h1234_5678;
    set_ra(4'd2, 4'd3, 4'd15);
    #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'h1234_5678;
`else
    want = 32'h0000_0055;
`endif
    checks++;
    if (bus.rd[31:0] !== want) begin
      failures++;
      $display("FAIL bypass_same_cycle rd=%h want %h", bus.rd[31:0], want);
    end
    step();
    idle();
    set_ra(4'd2, 4'd3, 4'd15);
    #1;
    checks++;
    if (bus.rd[31:0] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL bypass_next_cycle rd=%h want 12345678", bus.rd[31:0]);
    end
  endtask

  task automatic test_random();
    rf_addr_t a;
    for (int n = 0; n < 400; n++) begin
      bus.we_a    = 1'($urandom_range(0, 1));
      bus.wa_a    = rf_addr_t'($urandom_range(0, 15));
      bus.wd_a    = $urandom();
      bus.we_b    = 1'($urandom_range(0, 1));
      bus.wa_b    = ($urandom_range(0, 3) == 0) ? bus.wa_a : rf_addr_t'($urandom_range(0, 15));
      bus.wd_b    = $urandom();
      bus.sb_set  = ($urandom_range(0, 2) == 0);
      bus.sb_addr = ($urandom_range(0, 3) == 0) ? bus.wa_a : rf_addr_t'($urandom_range(0, 15));
      bus.ra      = 12'($urandom());
      bus.pc_in   = $urandom();
      #1;
      for (int p = 0; p < NRD; p++) begin
        a = bus.ra[p*4 +: 4];
        checks++;
        if (bus.rd[p*32 +: 32] !== exp_rd(a) || bus.rd_busy[p] !== exp_busy(a)) begin
          failures++;
          $display("FAIL random_read n=%0d port%0d r%0d rd=%h busy=%b want %h/%b", n, p, a,
                   bus.rd[p*32 +: 32], bus.rd_busy[p], exp_rd(a), exp_busy(a));
        end
      end
      step();
      checks++;
      if (bus.busy_cnt !== 5'(m_cnt()) || bus.sb_err !== m_err) begin
        failures++;
        $display("FAIL random_status n=%0d busy_cnt=%0d sb_err=%b want %0d/%b", n, bus.busy_cnt, bus.sb_err,
                 m_cnt(), m_err);
      end
    end
  endtask

  task automatic test_async_reset();
    idle();
    for (int i = 0; i < 15; i++) begin
      bus.we_a = 1'b1; bus.wa_a = rf_addr_t'(i); bus.wd_a = 32'h0;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.sb_set = 1'b1; bus.sb_addr = rf_addr_t'(8 + i);
      bus.we_b = 1'b1; bus.wa_b = rf_addr_t'(1 + i); bus.wd_b = 32'hC0DE_0000 + 32'(i + 1);
      step();
    end
    checks++;
    if (bus.busy_cnt !== 5'd4 || m_cnt() != 4) begin
      failures++;
      $display("FAIL async_setup busy_cnt=%0d want 4", bus.busy_cnt);
    end
    idle();
    bus.we_a = 1'b1; bus.wa_a = 4'd6; bus.wd_a = 32'hFFFF_0006;
    bus.sb_set = 1'b1; bus.sb_addr = 4'd12;
    set_ra(4'd1, 4'd2, 4'd8);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.busy_cnt !== 5'd0 || bus.sb_err !== 1'b0 || bus.rd !== 96'h0 || bus.rd_busy !== 3'b000) begin
      failures++;
      $display("FAIL async_reset busy_cnt=%0d sb_err=%b rd=%h rd_busy=%b want all 0", bus.busy_cnt, bus.sb_err,
               bus.rd, bus.rd_busy);
    end
    model_reset();
    @(posedge clk);
    #1;
    idle();
    #2 reset = 1'b1;
    bus.we_a = 1'b1; bus.wa_a = 4'd1; bus.wd_a = 32'h0000_CAFE;
    bus.sb_set = 1'b1; bus.sb_addr = 4'd9;
    step();
    idle();
    set_ra(4'd1, 4'd9, 4'd6);
    #1;
    checks++;
    if (bus.rd[31:0] !== 32'h0000_CAFE || bus.rd[95:64] !== 32'h0 || bus.busy_cnt !== 5'd1 ||
        bus.rd_busy !== 3'b010) begin
      failures++;
      $display("FAIL after_reset r1=%h r6=%h busy_cnt=%0d rd_busy=%b want 0000cafe/0/1/010", bus.rd[31:0],
               bus.rd[95:64], bus.busy_cnt, bus.rd_busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_collision();
    test_pc_write();
    test_scoreboard();
    test_illegal_set();
    test_bypass();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
